// File: rtl/alu_pkg.sv
// ALU flags unit shared definitions.
// Opcodes, flag bit positions and data widths.
package alu_pkg;

  localparam int WIDTH  = 8;
  localparam int OPW    = 4;
  localparam int FLAG_W = 4;

  // Flag bit positions inside {N,V,Z,C}
  localparam int FL_C = 0;
  localparam int FL_Z = 1;
  localparam int FL_V = 2;
  localparam int FL_N = 3;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_ADC  = 4'd1;
  localparam logic [OPW-1:0] OP_SUB  = 4'd2;
  localparam logic [OPW-1:0] OP_SBC  = 4'd3;
  localparam logic [OPW-1:0] OP_AND  = 4'd4;
  localparam logic [OPW-1:0] OP_OR   = 4'd5;
  localparam logic [OPW-1:0] OP_XOR  = 4'd6;
  localparam logic [OPW-1:0] OP_NOT  = 4'd7;
  localparam logic [OPW-1:0] OP_SHL  = 4'd8;
  localparam logic [OPW-1:0] OP_SHR  = 4'd9;
  localparam logic [OPW-1:0] OP_ROL  = 4'd10;
  localparam logic [OPW-1:0] OP_ROR  = 4'd11;
  localparam logic [OPW-1:0] OP_CMP  = 4'd12;
  localparam logic [OPW-1:0] OP_INC  = 4'd13;
  localparam logic [OPW-1:0] OP_DEC  = 4'd14;
  localparam logic [OPW-1:0] OP_PASS = 4'd15;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// In: alu_l, alu_r, op, cin. Out: res, c, v, upd_c, upd_v, wr_res.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0]   alu_l,
  input  logic [W-1:0]   alu_r,
  input  logic [OPW-1:0] op,
  input  logic           cin,
  output logic [W-1:0]   res,
  output logic           c,
  output logic           v,
  output logic           upd_c,
  output logic           upd_v,
  output logic           wr_res
);

  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W:0]   sum;
  logic         add_v;

  // One shared adder; subtraction is l + ~r + cin
  always_comb begin
    add_b  = alu_r;
    add_ci = 1'b0;
    unique case (op)
      OP_ADC: add_ci = cin;
      OP_SUB,
      OP_CMP: begin
        add_b  = ~alu_r;
        add_ci = 1'b1;
      end
      OP_SBC: begin
        add_b  = ~alu_r;
        add_ci = cin;
      end
      OP_INC: begin
        add_b  = '0;
        add_ci = 1'b1;
      end
      OP_DEC: begin
        add_b  = '1;
        add_ci = 1'b0;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, alu_l}
             + {1'b0, add_b}
             + {{W{1'b0}}, add_ci};

  // Operands agree in sign but sum does not
  assign add_v = (alu_l[W-1] == add_b[W-1])
              && (sum[W-1] != alu_l[W-1]);

  always_comb begin
    res    = sum[W-1:0];
    c      = sum[W];
    v      = add_v;
    upd_c  = 1'b0;
    upd_v  = 1'b0;
    wr_res = 1'b1;
    unique case (op)
      OP_ADD, OP_ADC,
      OP_SUB, OP_SBC: begin
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OP_CMP: begin
        upd_c  = 1'b1;
        upd_v  = 1'b1;
        wr_res = 1'b0;
      end
      OP_INC, OP_DEC: upd_v = 1'b1;
      OP_AND: begin
        res   = alu_l & alu_r;
        v     = 1'b0;
        upd_v = 1'b1;
      end
      OP_OR: begin
        res   = alu_l | alu_r;
        v     = 1'b0;
        upd_v = 1'b1;
      end
      OP_XOR: begin
        res   = alu_l ^ alu_r;
        v     = 1'b0;
        upd_v = 1'b1;
      end
      OP_NOT: begin
        res   = ~alu_l;
        v     = 1'b0;
        upd_v = 1'b1;
      end
      OP_PASS: begin
        res   = alu_l;
        v     = 1'b0;
        upd_v = 1'b1;
      end
      // Shifts touch C only; V keeps its value
      OP_SHL: begin
        res   = {alu_l[W-2:0], 1'b0};
        c     = alu_l[W-1];
        upd_c = 1'b1;
      end
      OP_SHR: begin
        res   = {1'b0, alu_l[W-1:1]};
        c     = alu_l[0];
        upd_c = 1'b1;
      end
      OP_ROL: begin
        res   = {alu_l[W-2:0], cin};
        c     = alu_l[W-1];
        upd_c = 1'b1;
      end
      OP_ROR: begin
        res   = {cin, alu_l[W-1:1]};
        c     = alu_l[0];
        upd_c = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_flags_unit.sv
// ALU with result/flags registers and bus drivers.
// Ports: clk, reset, alu_l, alu_r, op, calcn, outn, fl_loadn, fl_outn, bus, flags.
module alu_flags_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  alu_l,
  input  logic [WIDTH-1:0]  alu_r,
  input  logic [OPW-1:0]    op,
  input  logic              calcn,
  input  logic              outn,
  input  logic              fl_loadn,
  input  logic              fl_outn,
  inout  wire  [WIDTH-1:0]  bus,
  output logic [FLAG_W-1:0] flags
);

  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  result_d;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [WIDTH-1:0]  res;
  logic              c;
  logic              v;
  logic              upd_c;
  logic              upd_v;
  logic              wr_res;
  logic              res_oe;
  logic              fl_oe;
  logic              unused_bus;

  alu_core #(.W(WIDTH)) u_core (
    .alu_l  (alu_l),
    .alu_r  (alu_r),
    .op     (op),
    .cin    (flags_q[FL_C]),
    .res    (res),
    .c      (c),
    .v      (v),
    .upd_c  (upd_c),
    .upd_v  (upd_v),
    .wr_res (wr_res)
  );

  always_comb begin
    result_d = result_q;
    if (!calcn && wr_res) result_d = res;
  end

  // A bus load takes priority over the ALU flags
  always_comb begin
    flags_d = flags_q;
    if (!fl_loadn) begin
      flags_d = bus[FLAG_W-1:0];
    end else if (!calcn) begin
      flags_d[FL_Z] = (res == '0);
      flags_d[FL_N] = res[WIDTH-1];
      if (upd_c) flags_d[FL_C] = c;
      if (upd_v) flags_d[FL_V] = v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Result driver wins; flags buffer stays off
  assign res_oe = !reset && !outn;
  assign fl_oe  = !reset && !fl_outn && outn;

  assign bus = res_oe ? result_q
             : fl_oe  ? {{(WIDTH-FLAG_W){1'b0}}, flags_q}
             : 'z;

  assign unused_bus = ^bus[WIDTH-1:FLAG_W];
  assign flags      = flags_q;

endmodule
